// File: rtl/pad_cfg_pkg.sv
// Shared definitions for the pad-mux/pad-config register block and its
// scan-chain serializer.
package pad_cfg_pkg;

  localparam int PAD_CFG_BITS           = 6;
  localparam int PAD_FRAME_BITS_PER_PAD = 7;

  // Bit positions inside a pad's 6-bit config field
  localparam int PD   = 0;
  localparam int PU   = 1;
  localparam int SMT  = 2;
  localparam int SR   = 3;
  localparam int PIN1 = 4;
  localparam int PIN2 = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } pad_cfg_state_e;

endpackage

// File: rtl/pad_cfg_serializer_if.sv
// Register-block to serializer link: pad config in, scan-chain pins and status out.
interface pad_cfg_serializer_if
  import pad_cfg_pkg::*;
#(
  parameter int NUM_PADS = 32
);
  logic [NUM_PADS-1:0][PAD_CFG_BITS-1:0] pad_cfg_i;
  logic [NUM_PADS-1:0]                   pad_mux_i;
  logic                                  refresh_i;
  logic                                  cfg_sclk_o;
  logic                                  cfg_sdata_o;
  logic                                  cfg_latch_o;
  logic                                  busy_o;
  logic                                  done_o;

  modport master (
    output pad_cfg_i, pad_mux_i, refresh_i,
    input  cfg_sclk_o, cfg_sdata_o, cfg_latch_o, busy_o, done_o
  );

  modport slave (
    input  pad_cfg_i, pad_mux_i, refresh_i,
    output cfg_sclk_o, cfg_sdata_o, cfg_latch_o, busy_o, done_o
  );
endinterface

// File: rtl/pad_cfg_sclk_div.sv
// Half-period counter for the scan-chain clock: low phase first, then high,
// each CLK_DIV cycles long. Held cleared while en is low.
module pad_cfg_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en,
  output logic end_lo,
  output logic end_hi,
  output logic sclk
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt_q;
  logic             phase_q;
  logic             tc;

  assign tc     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign end_lo = en & ~phase_q & tc;
  assign end_hi = en & phase_q & tc;
  // Gated so the phase flip on the final tick never shows on the pin
  assign sclk   = en & phase_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else if (!en) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else if (tc) begin
      div_cnt_q <= '0;
      phase_q   <= ~phase_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/pad_cfg_serializer.sv
// Snapshots pad mux/config and shifts it into the pad-ring config chain,
// then strobes the chain latch.
//
//   state    | meaning
//   ST_IDLE  | waiting for init, refresh or an input change
//   ST_LOAD  | one cycle: capture snapshot and sent copy
//   ST_SHIFT | shifting FRAME_BITS bits, MSB (pad NUM_PADS-1 mux) first
//   ST_LATCH | latch strobe high for CLK_DIV cycles
module pad_cfg_serializer
  import pad_cfg_pkg::*;
#(
  parameter int NUM_PADS = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  pad_cfg_serializer_if.slave  bus
);
  localparam int FRAME_BITS = NUM_PADS * PAD_FRAME_BITS_PER_PAD;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  pad_cfg_state_e        state_q, state_d;
  logic [FRAME_BITS-1:0] cur_frame, snap_q, sent_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic                  init_pend_q, refresh_pend_q, done_q;
  logic                  start, last_bit, div_en, end_lo, end_hi, sclk;

  always_comb begin
    cur_frame = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      cur_frame[p*PAD_FRAME_BITS_PER_PAD +: PAD_FRAME_BITS_PER_PAD] =
        {bus.pad_mux_i[p], bus.pad_cfg_i[p]};
    end
  end

  assign start    = init_pend_q | refresh_pend_q | bus.refresh_i | (cur_frame != sent_q);
  assign last_bit = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
  // The divider keeps running through LATCH; its low-phase tick times the strobe
  assign div_en   = (state_q == ST_SHIFT) || (state_q == ST_LATCH);

  pad_cfg_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (div_en),
    .end_lo  (end_lo),
    .end_hi  (end_hi),
    .sclk    (sclk)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (end_hi && last_bit) state_d = ST_LATCH;
      ST_LATCH: if (end_lo) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      snap_q         <= '0;
      sent_q         <= '0;
      bit_cnt_q      <= '0;
      init_pend_q    <= 1'b1;
      refresh_pend_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= (state_q == ST_LATCH) && end_lo;
      if (state_q == ST_LOAD) begin
        snap_q         <= cur_frame;
        sent_q         <= cur_frame;
        bit_cnt_q      <= '0;
        init_pend_q    <= 1'b0;
        // A request landing in the LOAD cycle is still owed a later frame
        refresh_pend_q <= bus.refresh_i;
      end else begin
        if (bus.refresh_i && state_q != ST_IDLE) refresh_pend_q <= 1'b1;
        if (state_q == ST_SHIFT && end_hi && !last_bit) bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_q;
  assign bus.cfg_sclk_o  = sclk;
  assign bus.cfg_latch_o = (state_q == ST_LATCH);
  assign bus.cfg_sdata_o = div_en ? snap_q[BIT_W'(FRAME_BITS - 1) - bit_cnt_q] : 1'b0;
endmodule

// File: tb/tb_pad_cfg_serializer.sv
// Scoreboard bench: expected frames are queued when stimulus is applied and
// compared with frames captured from the chain pins.
`timescale 1ns/1ps
module tb_pad_cfg_serializer;
  import pad_cfg_pkg::*;

  localparam int NP  = 32;
  localparam int FB  = NP * 7;
  localparam int NP2 = 2;
  localparam int FB2 = NP2 * 7;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic rst2_n = 1'b0;
  always #5 HCLK = ~HCLK;

  pad_cfg_serializer_if #(.NUM_PADS(NP))  b1();
  pad_cfg_serializer_if #(.NUM_PADS(NP2)) b2();

  pad_cfg_serializer #(.NUM_PADS(NP), .CLK_DIV(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(b1));
  pad_cfg_serializer #(.NUM_PADS(NP2), .CLK_DIV(1)) dut_small (
    .HCLK(HCLK), .HRESETn(rst2_n), .bus(b2));

  typedef struct { logic [FB-1:0] bits; int n; } frame_t;

  int checks = 0;
  int passed = 0;

  logic [5:0]    cfg_m [NP];
  logic [NP-1:0] mux_m;
  logic [5:0]    cfg2_m [NP2];
  logic [NP2-1:0] mux2_m;

  logic [FB-1:0]  exp_q[$];
  logic [FB2-1:0] exp2_q[$];
  frame_t got_q[$];
  int busy_len_q[$], latch_len_q[$], idle_len_q[$];
  int done_cnt = 0;
  int nbits = 0;
  int busy_run = 0, latch_run = 0, idle_run = 0;
  logic prev_sclk = 0, prev_latch = 0, prev_busy = 0;
  logic [FB-1:0] cap = '0;

  // Pin monitor for the default-size instance
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      nbits = 0; cap = '0; busy_run = 0; latch_run = 0; idle_run = 0;
      prev_sclk = 0; prev_latch = 0; prev_busy = 0;
    end else begin
      if (b1.cfg_sclk_o && !prev_sclk) begin
        cap = {cap[FB-2:0], b1.cfg_sdata_o};
        nbits++;
      end
      if (b1.cfg_latch_o) latch_run++;
      else if (prev_latch) begin
        latch_len_q.push_back(latch_run);
        got_q.push_back('{cap, nbits});
        latch_run = 0; cap = '0; nbits = 0;
      end
      if (b1.busy_o) begin
        if (!prev_busy) idle_len_q.push_back(idle_run);
        busy_run++; idle_run = 0;
      end else begin
        if (prev_busy) begin busy_len_q.push_back(busy_run); busy_run = 0; end
        idle_run++;
      end
      if (b1.done_o) done_cnt++;
      prev_sclk = b1.cfg_sclk_o; prev_latch = b1.cfg_latch_o; prev_busy = b1.busy_o;
    end
  end

  function automatic logic [FB-1:0] model_frame();
    logic [FB-1:0] f = '0;
    for (int p = NP-1; p >= 0; p--) f = {f[FB-8:0], mux_m[p], cfg_m[p]};
    return f;
  endfunction

  function automatic logic [FB2-1:0] model_frame2();
    logic [FB2-1:0] f = '0;
    for (int p = NP2-1; p >= 0; p--) f = {f[FB2-8:0], mux2_m[p], cfg2_m[p]};
    return f;
  endfunction

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) b1.pad_cfg_i[p] = cfg_m[p];
    b1.pad_mux_i = mux_m;
  endtask

  task automatic flush();
    got_q.delete(); exp_q.delete(); busy_len_q.delete();
    latch_len_q.delete(); idle_len_q.delete(); done_cnt = 0;
  endtask

  task automatic pulse_refresh();
    step(); b1.refresh_i = 1'b1;
    step(); b1.refresh_i = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin @(negedge HCLK); c++; end
    if (got_q.size() < n) begin
      checks++;
      $display("FAIL wait_frames: got %0d frames, required %0d within %0d cycles", got_q.size(), n, budget);
    end
  endtask

  task automatic wait_bits(input int n, input int budget);
    int c = 0;
    while (nbits < n && c < budget) begin @(negedge HCLK); c++; end
    if (nbits < n) begin
      checks++;
      $display("FAIL wait_bits: got %0d bits, required %0d", nbits, n);
    end
  endtask

  task automatic cmp_frame(input string name);
    frame_t g;
    logic [FB-1:0] e;
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.bits !== e || g.n !== FB)
        $display("FAIL %s: got %h (%0d bits), required %h (%0d bits)", name, g.bits, g.n, e, FB);
      else passed++;
    end else begin
      checks++;
      $display("FAIL %s: got %0d frames, required %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    flush();
    for (int p = 0; p < NP; p++) cfg_m[p] = '0;
    mux_m = '0; drive(); b1.refresh_i = 1'b0;
    repeat (3) step();
    @(negedge HCLK);
    checks++;
    if ({b1.cfg_sclk_o, b1.cfg_sdata_o, b1.cfg_latch_o, b1.busy_o, b1.done_o} !== 5'b0)
      $display("FAIL reset_outputs: got %b, required 00000",
               {b1.cfg_sclk_o, b1.cfg_sdata_o, b1.cfg_latch_o, b1.busy_o, b1.done_o});
    else passed++;
    exp_q.push_back(model_frame());
    step(); HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (b1.busy_o !== 1'b0) $display("FAIL idle_eval_cycle: busy got %b, required 0", b1.busy_o);
    else passed++;
    @(negedge HCLK);
    checks++;
    if (b1.busy_o !== 1'b1) $display("FAIL start_latency: busy got %b, required 1", b1.busy_o);
    else passed++;
    wait_frames(1, 2500);
    repeat (60) @(negedge HCLK);
    cmp_frame("init_frame");
    checks++;
    if (busy_len_q.size() != 1 || busy_len_q[0] != 1797)
      $display("FAIL busy_len: got %0d (entries %0d), required 1797", busy_len_q.size() > 0 ? busy_len_q[0] : -1, busy_len_q.size());
    else passed++;
    checks++;
    if (latch_len_q.size() != 1 || latch_len_q[0] != 4)
      $display("FAIL latch_len: got %0d, required 4", latch_len_q.size() > 0 ? latch_len_q[0] : -1);
    else passed++;
    checks++;
    if (done_cnt != 1) $display("FAIL done_pulse: got %0d cycles, required 1", done_cnt);
    else passed++;
    checks++;
    if (b1.busy_o !== 1'b0 || got_q.size() != 0)
      $display("FAIL single_init_frame: busy %b extra frames %0d, required 0 0", b1.busy_o, got_q.size());
    else passed++;
  endtask

  task automatic test_pattern();
    frame_t g;
    flush();
    mux_m = 32'h8000_0000;
    cfg_m[0][PD] = 1'b1; cfg_m[0][PIN2] = 1'b1;
    step(); drive();
    exp_q.push_back(model_frame());
    wait_frames(1, 2500);
    repeat (5) @(negedge HCLK);
    if (got_q.size() > 0) begin
      g = got_q[0];
      checks++;
      if (g.bits[FB-1] !== 1'b1) $display("FAIL first_bit: got %b, required 1", g.bits[FB-1]);
      else passed++;
      checks++;
      if (g.bits[6:0] !== 7'b0100001) $display("FAIL last_7_bits: got %b, required 0100001", g.bits[6:0]);
      else passed++;
    end
    cmp_frame("pattern_frame");
    checks++;
    if (latch_len_q.size() != 1 || latch_len_q[0] != 4)
      $display("FAIL pattern_latch_len: got %0d, required 4", latch_len_q.size() > 0 ? latch_len_q[0] : -1);
    else passed++;
  endtask

  task automatic test_midframe_change();
    frame_t g;
    flush();
    step(); b1.refresh_i = 1'b1;
    exp_q.push_back(model_frame());
    step(); b1.refresh_i = 1'b0;
    wait_bits(100, 1500);
    step(); cfg_m[5] = 6'h3F; drive();
    exp_q.push_back(model_frame());
    idle_len_q.delete();
    wait_frames(2, 4500);
    repeat (5) @(negedge HCLK);
    if (got_q.size() > 1) begin
      g = got_q[1];
      checks++;
      if (g.bits[5*7 +: 6] !== 6'h3F) $display("FAIL pad5_new: got %h, required 3f", g.bits[5*7 +: 6]);
      else passed++;
    end
    cmp_frame("mid_old_frame");
    cmp_frame("mid_new_frame");
    checks++;
    if (idle_len_q.size() != 1 || idle_len_q[0] != 1)
      $display("FAIL idle_gap: got %0d, required 1", idle_len_q.size() > 0 ? idle_len_q[0] : -1);
    else passed++;
  endtask

  task automatic test_refresh_coalesce();
    flush();
    step(); b1.refresh_i = 1'b1;
    exp_q.push_back(model_frame());
    step(); b1.refresh_i = 1'b0;
    wait_bits(20, 1000);
    repeat (3) begin
      pulse_refresh();
      repeat (10) step();
    end
    exp_q.push_back(model_frame());
    wait_frames(2, 4500);
    repeat (60) @(negedge HCLK);
    cmp_frame("refresh_frame_a");
    cmp_frame("refresh_frame_b");
    checks++;
    if (busy_len_q.size() != 2 || b1.busy_o !== 1'b0)
      $display("FAIL refresh_coalesce: got %0d frames busy %b, required 2 frames busy 0", busy_len_q.size(), b1.busy_o);
    else passed++;
  endtask

  task automatic test_refresh_and_change();
    flush();
    step();
    cfg_m[10] = 6'h0C; mux_m[3] = 1'b1; drive();
    b1.refresh_i = 1'b1;
    exp_q.push_back(model_frame());
    step(); b1.refresh_i = 1'b0;
    wait_frames(1, 2500);
    repeat (60) @(negedge HCLK);
    cmp_frame("combo_frame");
    checks++;
    if (busy_len_q.size() != 1 || b1.busy_o !== 1'b0)
      $display("FAIL combo_single: got %0d frames busy %b, required 1 frame busy 0", busy_len_q.size(), b1.busy_o);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    flush();
    pulse_refresh();
    wait_bits(50, 1000);
    step(); HRESETn = 1'b0;
    #1;
    checks++;
    if ({b1.cfg_sclk_o, b1.cfg_sdata_o, b1.cfg_latch_o, b1.busy_o, b1.done_o} !== 5'b0)
      $display("FAIL async_reset: got %b, required 00000",
               {b1.cfg_sclk_o, b1.cfg_sdata_o, b1.cfg_latch_o, b1.busy_o, b1.done_o});
    else passed++;
    step(); step();
    flush();
    exp_q.push_back(model_frame());
    HRESETn = 1'b1;
    wait_frames(1, 2500);
    repeat (5) @(negedge HCLK);
    cmp_frame("post_reset_frame");
    checks++;
    if (latch_len_q.size() != 1 || latch_len_q[0] != 4)
      $display("FAIL post_reset_latch: got %0d pulses, required 1 pulse of 4", latch_len_q.size());
    else passed++;
  endtask

  task automatic test_small();
    int busy_n = 0, rises = 0, latch_n = 0, done_n = 0, tog_err = 0, k = 0;
    logic prev = 1'b0;
    logic [FB2-1:0] cap2 = '0;
    logic [FB2-1:0] e;
    exp2_q.push_back(model_frame2());
    step(); rst2_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge HCLK);
      if (b2.busy_o) begin
        busy_n++;
        if (busy_n > 1 && !b2.cfg_latch_o) begin
          if (b2.cfg_sclk_o !== ((k % 2) == 1)) tog_err++;
          k++;
        end
      end
      if (b2.cfg_latch_o) latch_n++;
      if (b2.done_o) done_n++;
      if (b2.cfg_sclk_o && !prev) begin cap2 = {cap2[FB2-2:0], b2.cfg_sdata_o}; rises++; end
      prev = b2.cfg_sclk_o;
    end
    e = exp2_q.pop_front();
    checks++;
    if (cap2 !== e) $display("FAIL small_frame: got %b, required %b", cap2, e);
    else passed++;
    checks++;
    if (rises != 14) $display("FAIL small_rises: got %0d, required 14", rises);
    else passed++;
    checks++;
    if (busy_n != 30) $display("FAIL small_busy_len: got %0d, required 30", busy_n);
    else passed++;
    checks++;
    if (tog_err != 0 || k != 28) $display("FAIL small_toggle: got %0d errors over %0d cycles, required 0 over 28", tog_err, k);
    else passed++;
    checks++;
    if (latch_n != 1 || done_n != 1) $display("FAIL small_latch_done: got latch %0d done %0d, required 1 1", latch_n, done_n);
    else passed++;
  endtask

  initial begin
    cfg2_m[1] = 6'h15; cfg2_m[0] = 6'h2A; mux2_m = 2'b10;
    b2.pad_cfg_i[1] = cfg2_m[1]; b2.pad_cfg_i[0] = cfg2_m[0];
    b2.pad_mux_i = mux2_m; b2.refresh_i = 1'b0;
    b1.refresh_i = 1'b0;
    test_reset();
    test_pattern();
    test_midframe_change();
    test_refresh_coalesce();
    test_refresh_and_change();
    test_reset_midframe();
    test_small();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
